fetch_logic: RTL and testbench
==============================

# fetch_logic

Instruction fetch stage of the RV32I core, directly upstream of `decode_logic`. Holds the program counter and issues in-order word fetches to instruction memory. Buffers returned words with their PCs in a small FIFO and presents them to decode under a valid/ready handshake. On `jump_branch_enable` it flushes buffered and in-flight instructions and redirects to the target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 4, instruction buffer entries; power of two, 2..16; also caps fetches in flight

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `jump_branch_enable` in 1: redirect request; same signal decode receives
- `jump_branch_addr` in 32: redirect target
- `imem_req` out 1: fetch request
- `imem_addr` out 32: fetch address, word aligned
- `imem_gnt` in 1: request accepted this cycle
- `imem_rvalid` in 1: read data valid; responses in order, ≥1 cycle after grant
- `imem_rdata` in 32: read data
- `instruction` out 32: FIFO head word, to decode
- `instr_pc` out 32: PC of `instruction`
- `instr_valid` out 1: FIFO non-empty
- `decode_ready` in 1: decode consumes head this cycle
- `fetch_misaligned` out 1: only with `FETCH_MISALIGN_TRAP_EN`

## Operation
- Registers: `pc` (next fetch address), `resp_pc` (PC of next kept response), FIFO of {word, pc}, `outstanding` and `discard` counters, each clog2(FIFO_DEPTH)+1 bits.
- Issue: `imem_req` = !reset && !`jump_branch_enable` && (fifo_count + outstanding < FIFO_DEPTH), plus no misalignment trap (macro only). `imem_addr` = `pc`. Both are combinational from registers.
- Grant (`imem_req && imem_gnt`): `pc += 4` (wraps modulo 2^32); `outstanding++`.
- Response (`imem_rvalid`): `outstanding--`. If `discard` > 0, `discard--` and the data is dropped. Otherwise {`imem_rdata`, `resp_pc`} is pushed and `resp_pc += 4`.
- Pop: `instr_valid && decode_ready` removes the head. Simultaneous push and pop leaves the count unchanged.
- Flush (`jump_branch_enable`=1 at edge):
  - `pc` and `resp_pc` load the target.
  - The FIFO is emptied.
  - `discard` loads all in-flight fetches, i.e. `outstanding` minus any response arriving that same cycle. A response arriving in the flush cycle is also dropped, never pushed.
  - No grant occurs in the flush cycle because `imem_req` is forced low.
- Target low bits without the macro: `jump_branch_addr[1:0]` are forced to 00.
- Empty FIFO: `instruction` and `instr_pc` drive 0.
- An `imem_rvalid` with `outstanding`=0 is a protocol violation. Its behaviour is undefined; assertion only.

## Timing
- Reset values: `pc`=`resp_pc`=`RESET_PC`, FIFO empty, counters 0, `instr_valid`=0, `instruction`=0, `instr_pc`=0, `imem_req`=0 while reset is high, `fetch_misaligned`=0.
- First cycle after reset deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- With a single-cycle grant, `imem_req` can stay high and issue one fetch per cycle.
- Latency: a response in cycle N gives `instr_valid` at N+1. There is no bypass.
- Flush at edge E: `instr_valid`=0 after E. The first request to the target is made in cycle E+1. The first kept instruction appears one cycle after its response.
- A flush while the FIFO is full or `outstanding`=FIFO_DEPTH is legal. Issue resumes in the cycle after the flush as credits allow, so the discarded in-flight fetches still count.
- Reset mid-operation discards all state. Late responses after reset are not tracked; the memory is reset with the core.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A flush with `jump_branch_addr[1:0]`≠0 sets `fetch_misaligned` at the next edge.
  - It holds `imem_req` low until reset or a flush to an aligned target.
  - Flushing and discarding still proceed.
- Undefined: the port is absent and the low two target bits are forced to 00.

## Test plan
- Reset then zero-wait memory (gnt=1, rvalid one cycle later), `decode_ready`=1 -> addresses 0,4,8,… once per cycle; `instr_pc` 0,4,8 with matching data; first `instr_valid` 3 cycles after reset drop.
- `decode_ready`=0 with FIFO_DEPTH=4 -> exactly 4 grants, FIFO full, `imem_req`=0; a single ready pulse -> one pop, then one new request.
- Four in flight, then flush to 32'h0000_0100 -> 4 responses dropped, FIFO stays empty, next `instr_pc`=0x100 with data from address 0x100.
- Flush in the same cycle as an `imem_rvalid` and a pop -> that response dropped, `discard` correct, no stale instruction appears.
- `pc` at 32'hFFFF_FFFC -> next address 0, `instr_pc` wraps to 0.
- Macro on, flush to 0x102 -> `fetch_misaligned`=1, no requests; flush to 0x200 clears it and fetching resumes at 0x200. Macro off: same flush fetches 0x100.

Source files
------------

// File: rtl/fetch_logic.sv
// fetch_logic: RV32I fetch stage - PC, in-order imem requests, {word, pc} buffer presented to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN adds fetch_misaligned and stalls fetch after an unaligned redirect.
module fetch_logic #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_branch_enable,
    input  logic [31:0] jump_branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        decode_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_r, resp_pc_r;
    logic [31:0]   word_mem_r [FIFO_DEPTH];
    logic [31:0]   pc_mem_r   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_r, wr_ptr_r;
    logic [CW-1:0] count_r, outstanding_r, discard_r;

    logic [31:0]   pc_nxt_s, resp_pc_nxt_s, target_s;
    logic [AW-1:0] rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s, outstanding_nxt_s, discard_nxt_s;
    logic [CW:0]   credit_used_s;
    logic          stall_s, grant_s, push_s, pop_s, drop_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_r;

    assign stall_s          = misaligned_r;
    assign fetch_misaligned = misaligned_r;
    assign target_s         = {jump_branch_addr[31:2], 2'b00};

    // Sticky trap: set by an unaligned redirect, cleared by reset or an aligned redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_r <= 1'b0;
        end else if (jump_branch_enable) begin
            misaligned_r <= (jump_branch_addr[1:0] != 2'b00);
        end else begin
            misaligned_r <= misaligned_r;
        end
    end
`else
    assign stall_s  = 1'b0;
    assign target_s = jump_branch_addr & 32'hFFFF_FFFC;
`endif

    // Discarded in-flight fetches still hold credits until their responses return
    assign credit_used_s = {1'b0, count_r} + {1'b0, outstanding_r};
    assign imem_req      = !reset && !jump_branch_enable && !stall_s && (credit_used_s < DEPTH_W);
    assign imem_addr     = pc_r;
    assign instr_valid   = (count_r != {CW{1'b0}});

    assign grant_s = imem_req && imem_gnt;
    assign drop_s  = imem_rvalid && (discard_r != {CW{1'b0}});
    assign push_s  = imem_rvalid && (discard_r == {CW{1'b0}}) && !jump_branch_enable;
    assign pop_s   = instr_valid && decode_ready && !jump_branch_enable;

    // Head of buffer to decode, zero when empty
    always_comb begin
        instruction = 32'h0000_0000;
        instr_pc    = 32'h0000_0000;
        if (instr_valid) begin
            instruction = word_mem_r[rd_ptr_r];
            instr_pc    = pc_mem_r[rd_ptr_r];
        end else begin
            instruction = 32'h0000_0000;
            instr_pc    = 32'h0000_0000;
        end
    end

    // Next-state: redirect overrides normal issue/response/pop bookkeeping
    always_comb begin
        pc_nxt_s          = pc_r;
        resp_pc_nxt_s     = resp_pc_r;
        rd_ptr_nxt_s      = rd_ptr_r;
        wr_ptr_nxt_s      = wr_ptr_r;
        count_nxt_s       = count_r;
        outstanding_nxt_s = outstanding_r;
        discard_nxt_s     = discard_r;
        if (jump_branch_enable) begin
            pc_nxt_s          = target_s;
            resp_pc_nxt_s     = target_s;
            rd_ptr_nxt_s      = {AW{1'b0}};
            wr_ptr_nxt_s      = {AW{1'b0}};
            count_nxt_s       = {CW{1'b0}};
            // A response landing in the redirect cycle is already dropped, so it is not re-counted
            outstanding_nxt_s = outstanding_r - CW'(imem_rvalid);
            discard_nxt_s     = outstanding_r - CW'(imem_rvalid);
        end else begin
            if (grant_s) begin
                pc_nxt_s = pc_r + 32'd4;
            end else begin
                pc_nxt_s = pc_r;
            end
            outstanding_nxt_s = outstanding_r + CW'(grant_s) - CW'(imem_rvalid);
            if (drop_s) begin
                discard_nxt_s = discard_r - CW'(1'b1);
            end else begin
                discard_nxt_s = discard_r;
            end
            if (push_s) begin
                resp_pc_nxt_s = resp_pc_r + 32'd4;
                wr_ptr_nxt_s  = wr_ptr_r + AW'(1'b1);
            end else begin
                resp_pc_nxt_s = resp_pc_r;
                wr_ptr_nxt_s  = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
        end else begin
            pc_r          <= pc_nxt_s;
            resp_pc_r     <= resp_pc_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            count_r       <= count_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
        end
    end

    // Buffer storage; contents are only visible through count_r, so no reset needed
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            word_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]   <= resp_pc_r;
        end
    end

    fetch_logic_checker #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) u_checker (
        .clk         (clk),
        .reset       (reset),
        .imem_rvalid (imem_rvalid),
        .outstanding (outstanding_r),
        .count       (count_r)
    );
endmodule

// fetch_logic_checker: memory-protocol and credit assertions for fetch_logic.
module fetch_logic_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          imem_rvalid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] count
);
    rvalid_needs_fetch: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (outstanding != {CW{1'b0}}));

    credit_bound: assert property (@(posedge clk) disable iff (reset)
        (({1'b0, count} + {1'b0, outstanding}) <= (CW + 1)'(FIFO_DEPTH)));
endmodule

// File: tb/tb_fetch_logic.sv
// tb_fetch_logic: randomized fetch-stage bench; an epoch-tagged memory model feeds a scoreboard of expected {pc, word}.
module tb_fetch_logic;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, jbe, gnt, rvalid, ready, req, ivalid;
    logic [31:0] jba, addr, rdata, instr, ipc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis;
`endif

    always #5 clk = ~clk;

    fetch_logic #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .jump_branch_enable (jbe),
        .jump_branch_addr   (jba),
        .imem_req           (req),
        .imem_addr          (addr),
        .imem_gnt           (gnt),
        .imem_rvalid        (rvalid),
        .imem_rdata         (rdata),
        .instruction        (instr),
        .instr_pc           (ipc),
        .instr_valid        (ivalid),
        .decode_ready       (ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned   (mis)
`endif
    );

    typedef struct { logic [31:0] a_exp; logic [31:0] a_dut; int unsigned ep; int cyc; } fetch_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;

    fetch_t      pend_q[$];
    entry_t      sb_q[$];
    int unsigned epoch   = 0;
    logic [31:0] exp_pc  = RPC;
    logic        exp_mis = 1'b0;
    bit          started = 1'b0;
    int          tests = 0, fails = 0, pops = 0, cur_cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cur_cyc);
        end
    endtask

    // Monitor: compares presented outputs against the scoreboard, consumes entries on handshakes
    initial begin : monitor
        logic exp_req;
        forever begin
            @(negedge clk);
            #1;
            if (started) begin
                exp_req = !reset && !jbe && !exp_mis && ((sb_q.size() + pend_q.size()) < DEPTH);
                check("imem_req", {31'h0, req}, {31'h0, exp_req});
                if (exp_req) check("imem_addr", addr, exp_pc);
                check("instr_valid", {31'h0, ivalid}, {31'h0, (sb_q.size() != 0)});
`ifdef FETCH_MISALIGN_TRAP_EN
                check("fetch_misaligned", {31'h0, mis}, {31'h0, exp_mis});
`endif
                if (ivalid && sb_q.size() != 0) begin
                    check("instr_pc", ipc, sb_q[0].pc);
                    check("instruction", instr, sb_q[0].data);
                end else if (!ivalid) begin
                    check("empty_instruction", instr, 32'h0);
                    check("empty_instr_pc", ipc, 32'h0);
                end
                if (!reset && !jbe && ivalid && ready && sb_q.size() != 0) begin
                    void'(sb_q.pop_front());
                    pops++;
                end
            end
        end
    end

    // Stimulus + memory model: drives inputs, then records what the coming edge does
    initial begin : stimulus
        fetch_t      f;
        entry_t      e;
        int          gp, vp, rp, fp;
        bit          force_fl;
        logic [31:0] force_tgt;
        reset = 1'b1; jbe = 1'b0; jba = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; ready = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            cur_cyc = c;
            gp = 70; vp = 60; rp = 60; fp = 4; force_fl = 1'b0; force_tgt = 32'h0;
            reset = (c < 3) || (c == 1500) || (c == 1501);
            if (c >= 3 && c <= 170) begin gp = 100; vp = 100; rp = 100; fp = 0; end
            if (c >= 41 && c <= 70 && c != 61) rp = 0;
            if (c >= 81 && c <= 86) vp = 0;
            case (c)
                86:      begin force_fl = 1'b1; force_tgt = 32'h0000_0100; end
                100:     begin force_fl = 1'b1; force_tgt = 32'h0000_0300; end
                111:     begin force_fl = 1'b1; force_tgt = 32'hFFFF_FFF8; end
                141:     begin force_fl = 1'b1; force_tgt = 32'h0000_0102; end
                161:     begin force_fl = 1'b1; force_tgt = 32'h0000_0200; end
                default: force_fl = 1'b0;
            endcase
            gnt   = ($urandom_range(0, 99) < gp);
            ready = ($urandom_range(0, 99) < rp);
            if (reset) begin
                jbe = 1'b0;
            end else if (force_fl) begin
                jbe = 1'b1; jba = force_tgt;
            end else if ($urandom_range(0, 99) < fp) begin
                jbe = 1'b1;
                if ($urandom_range(0, 7) == 0) jba = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else jba = 32'($urandom_range(0, 4095));
            end else begin
                jbe = 1'b0; jba = $urandom();
            end
            rvalid = 1'b0;
            rdata  = $urandom();
            if (!reset && pend_q.size() != 0) begin
                if (pend_q[0].cyc < c && $urandom_range(0, 99) < vp) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(pend_q[0].a_dut);
                end
            end
            #2;
            if (reset) begin
                sb_q.delete(); pend_q.delete();
                exp_pc = RPC; exp_mis = 1'b0; epoch++;
            end else begin
                if (rvalid) begin
                    f = pend_q.pop_front();
                    if (!jbe && f.ep == epoch) begin
                        e.pc = f.a_exp; e.data = mem_word(f.a_exp);
                        sb_q.push_back(e);
                    end
                end
                if (jbe) begin
                    sb_q.delete();
                    epoch++;
                    exp_pc = jba & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
                    exp_mis = (jba[1:0] != 2'b00);
`endif
                end else if (req && gnt) begin
                    f.a_exp = exp_pc; f.a_dut = addr; f.ep = epoch; f.cyc = c;
                    pend_q.push_back(f);
                    exp_pc = exp_pc + 32'd4;
                end
            end
            started = 1'b1;
        end
        @(negedge clk);
        tests++;
        if (pops < 200) begin
            fails++;
            $display("FAIL progress: got %0d pops expected at least 200", pops);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
